// File: rtl/perf_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank_if
//  Purpose  : Read-port bundle of the performance counter bank.
//             master = requester, slave = counter bank.
//  Revision : 1.0  initial release
// ============================================================================
interface perf_counter_bank_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32
) ();
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;

  modport master (output rd_en, output rd_sel, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_sel, output rd_data, output rd_valid);
endinterface
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank
//  Purpose  : Cycle counter plus NUM_CH event counters with optional stall
//             qualification, saturate/wrap overflow, halt/watchdog freeze and
//             a two-stage registered read port (pre-increment snapshot).
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter_bank #(
  parameter int          NUM_CH     = 8,
  parameter int          CNT_W      = 32,
  parameter int          SAT        = 1,
  parameter logic [15:0] QUAL_MASK  = 16'h00F0,
  parameter int          WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              stall,
  input  logic [NUM_CH-1:0] evt,
  input  logic              hlt,
  perf_counter_bank_if.slave rd,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen,
  output logic              wdog_tripped
);

  localparam int               SEL_W     = $clog2(NUM_CH + 1);
  localparam int               TAB_N     = 1 << SEL_W;
  localparam bit               WDOG_EN   = (WDOG_LIMIT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             count_en;
  logic             wdog_hit;
  logic [CNT_W-1:0] ch_cnt [NUM_CH];
  logic [CNT_W-1:0] tab    [TAB_N];
  logic             rd_pend;
  logic [CNT_W-1:0] rd_snap;

  // Counting happens only on RUN edges; clr drops that cycle's events.
  assign count_en = (state == RUN) && !clr;
  assign wdog_hit = WDOG_EN && (cycle_cnt == WDOG_LAST);

  // Status outputs come straight from the state register.
  assign frozen       = (state == HALTED) || (state == TIMEOUT);
  assign wdog_tripped = (state == TIMEOUT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: clr first, then halt beats watchdog beats pause.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = RUN;
        RUN: begin
          if (hlt)           state_nxt = HALTED;
          else if (wdog_hit) state_nxt = TIMEOUT;
          else if (!en)      state_nxt = IDLE;
        end
        HALTED:  state_nxt = HALTED;
        TIMEOUT: state_nxt = TIMEOUT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Cycle counter: same saturate/wrap rule as the channels, no overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (clr) begin
      cycle_cnt <= '0;
    end else if (count_en) begin
      if (&cycle_cnt) cycle_cnt <= (SAT != 0) ? cycle_cnt : '0;
      else            cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             inc;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    // Qualified channels ignore events raised while the pipeline stalls.
    assign inc       = evt[i] && (!QUAL_MASK[i] || !stall);
    assign ch_cnt[i] = cnt_q;
    assign ovf[i]    = ovf_q;

    // Event counter with sticky overflow on any event arriving at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (clr) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (count_en && inc) begin
        if (&cnt_q) begin
          ovf_q <= 1'b1;
          cnt_q <= (SAT != 0) ? cnt_q : '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Read table padded to a power of two so any rd_sel indexes it safely;
  // entries above the cycle counter read as zero.
  for (genvar t = 0; t < TAB_N; t++) begin : g_tab
    if (t < NUM_CH) begin : g_chan
      assign tab[t] = ch_cnt[t];
    end else if (t == NUM_CH) begin : g_cyc
      assign tab[t] = cycle_cnt;
    end else begin : g_zero
      assign tab[t] = '0;
    end
  end

  // Read pipeline: snapshot pre-update value, present it one edge later.
  // clr deliberately leaves an in-flight read untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend     <= 1'b0;
      rd_snap     <= '0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
    end else begin
      rd_pend     <= rd.rd_en;
      rd.rd_valid <= rd_pend;
      if (rd.rd_en) rd_snap    <= tab[rd.rd_sel];
      if (rd_pend)  rd.rd_data <= rd_snap;
    end
  end

endmodule
`default_nettype wire
